// File: rtl/ff_array_pkg.sv
// ff_array_pkg: shared types and helpers for the two-port flip-flop array
package ff_array_pkg;
   typedef enum logic {INIT, READY} ff_array_state_t;
   function automatic int lane_count(input int width, input int gran);
      return width / gran;
   endfunction
endpackage

// File: rtl/ff_array_clr_ctrl.sv
// ff_array_clr_ctrl: init/ready FSM and sequential clear counter
module ff_array_clr_ctrl
   import ff_array_pkg::*;
#(
   parameter int S_INDEX = 4
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               flush,
   output logic               ready,
   output logic               clr_we,
   output logic [S_INDEX-1:0] clr_addr
);
   ff_array_state_t    state_q, state_d;
   logic [S_INDEX-1:0] cnt_q, cnt_d;
   // sweep every index once, then serve; a flush in READY restarts the sweep
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = &cnt_q ? READY : INIT;
      end else if (flush) begin
         state_d = INIT;
         cnt_d   = '0;
      end
   end
   // state register; counter wraps to 0 on the INIT->READY edge
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign ready    = state_q == READY;
   assign clr_we   = state_q == INIT && rstb;
   assign clr_addr = cnt_q;
endmodule

// File: rtl/ff_array_2p.sv
// ff_array_2p: flip-flop array with masked read/write port 0 and read-only port 1
module ff_array_2p
   import ff_array_pkg::*;
#(
   parameter int               S_INDEX    = 4,
   parameter int               WIDTH      = 32,
   parameter int               GRAN       = 8,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                                clk0,
   input  logic                                rstb0,
   input  logic                                flush0,
   output logic                                ready0,
   input  logic                                csb0,
   input  logic                                web0,
   input  logic [lane_count(WIDTH, GRAN)-1:0]  wmask0,
   input  logic [S_INDEX-1:0]                  addr0,
   input  logic [WIDTH-1:0]                    din0,
   output logic [WIDTH-1:0]                    dout0,
   input  logic                                csb1,
   input  logic [S_INDEX-1:0]                  addr1,
   output logic [WIDTH-1:0]                    dout1
);
   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam int LANES    = lane_count(WIDTH, GRAN);
   if (WIDTH % GRAN != 0) begin : g_bad_gran
      $error("ff_array_2p: WIDTH must be a multiple of GRAN");
   end
   logic               clr_we;
   logic [S_INDEX-1:0] clr_addr;
   logic [WIDTH-1:0]   mem_q [NUM_SETS];
   logic [WIDTH-1:0]   mem_d [NUM_SETS];
   logic [S_INDEX-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic               wr_en;
   ff_array_clr_ctrl #(.S_INDEX(S_INDEX)) u_clr (
      .clk      (clk0),
      .rstb     (rstb0),
      .flush    (flush0),
      .ready    (ready0),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );
   // reset edges leave contents alone, so writes also require rstb0 high
   assign wr_en = ready0 && rstb0 && !csb0 && !web0;
   // next contents: clear engine during INIT, otherwise lane-masked port 0 write
   always_comb begin
      mem_d = mem_q;
      if (clr_we)
         mem_d[clr_addr] = INIT_VALUE;
      else if (wr_en)
         for (int i = 0; i < LANES; i++)
            if (wmask0[i]) mem_d[addr0][i*GRAN +: GRAN] = din0[i*GRAN +: GRAN];
   end
   // storage has no reset; the clear engine initialises it
   always_ff @(posedge clk0) mem_q <= mem_d;
   // index capture only when selected and ready; otherwise hold
   always_comb begin
      addr0_d = (ready0 && !csb0) ? addr0 : addr0_q;
      addr1_d = (ready0 && !csb1) ? addr1 : addr1_q;
   end
   // registered read indices
   always_ff @(posedge clk0) begin
      if (!rstb0) begin
         addr0_q <= '0;
         addr1_q <= '0;
      end else begin
         addr0_q <= addr0_d;
         addr1_q <= addr1_d;
      end
   end
   assign dout0 = ready0 ? mem_q[addr0_q] : '0;
   assign dout1 = ready0 ? mem_q[addr1_q] : '0;
endmodule

// File: tb/tb_ff_array_2p.sv
// tb_ff_array_2p: directed vector bench for ff_array_2p
module tb_ff_array_2p;
   localparam logic [31:0] IV = 32'hA5A5A5A5;
   logic        clk0 = 0, rstb0, flush0, ready0, csb0, web0, csb1;
   logic [3:0]  wmask0, addr0, addr1;
   logic [31:0] din0, dout0, dout1;
   int total = 0, bad = 0;
   typedef struct {
      logic        csb0, web0;
      logic [3:0]  wmask0, addr0;
      logic [31:0] din0;
      logic        csb1;
      logic [3:0]  addr1;
      logic [31:0] exp0, exp1;
   } vec_t;
   vec_t vecs[10];

   ff_array_2p #(.S_INDEX(4), .WIDTH(32), .GRAN(8), .INIT_VALUE(IV)) dut (
      .clk0(clk0), .rstb0(rstb0), .flush0(flush0), .ready0(ready0),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
      .csb1(csb1), .addr1(addr1), .dout1(dout1)
   );

   always #5 clk0 = ~clk0;

   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle();
      csb0 = 1; web0 = 1; wmask0 = 4'h0; addr0 = 0; din0 = 0; csb1 = 1; addr1 = 0; flush0 = 0;
   endtask

   task automatic wait_clear(input string name);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk(name, {31'b0, ready0}, {31'b0, k == 16});
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 4'hF, 4'd3,  32'h00000000, 1'b0, 4'd3,  32'h00000000, 32'h00000000};
      vecs[1] = '{1'b0, 1'b0, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'd3,  32'h00220044, 32'h00220044};
      vecs[2] = '{1'b0, 1'b0, 4'hF, 4'd5,  32'hDEADBEEF, 1'b0, 4'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b1, 4'hF, 4'd4,  32'h00000000, 1'b0, 4'd3,  IV,           32'h00220044};
      vecs[4] = '{1'b0, 1'b0, 4'h0, 4'd5,  32'hFFFFFFFF, 1'b1, 4'd0,  32'hDEADBEEF, 32'h00220044};
      vecs[5] = '{1'b1, 1'b0, 4'hF, 4'd5,  32'h00000000, 1'b0, 4'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 1'b1, 4'hF, 4'd7,  32'h00000000, 1'b1, 4'd9,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 1'b1, 4'h0, 4'd5,  32'h00000000, 1'b0, 4'd4,  32'hDEADBEEF, IV};
      vecs[8] = '{1'b0, 1'b0, 4'h8, 4'd0,  32'h77000000, 1'b0, 4'd15, 32'h77A5A5A5, IV};
      vecs[9] = '{1'b0, 1'b0, 4'h2, 4'd15, 32'h0000BB00, 1'b0, 4'd0,  32'hA5A5BBA5, 32'h77A5A5A5};

      // reset for two edges
      idle();
      rstb0 = 0;
      tick();
      tick();
      chk("rst_ready", {31'b0, ready0}, 32'd0);
      chk("rst_dout0", dout0, 32'd0);
      chk("rst_dout1", dout1, 32'd0);

      // clear with port requests and flush asserted throughout INIT
      rstb0 = 1;
      csb0 = 0; web0 = 0; wmask0 = 4'hF; addr0 = 4'd6; din0 = 0; csb1 = 0; addr1 = 4'd6; flush0 = 1;
      wait_clear("init_ready");
      idle();
      chk("init_noaddr0", dout0, IV);
      chk("init_noaddr1", dout1, IV);

      // every entry holds the init value
      for (int i = 0; i < 16; i++) begin
         csb0 = 0; addr0 = 4'(i); csb1 = 0; addr1 = 4'(15 - i);
         tick();
         chk("init_rd0", dout0, IV);
         chk("init_rd1", dout1, IV);
      end

      // table-driven vectors
      for (int v = 0; v < 10; v++) begin
         csb0 = vecs[v].csb0; web0 = vecs[v].web0; wmask0 = vecs[v].wmask0;
         addr0 = vecs[v].addr0; din0 = vecs[v].din0; csb1 = vecs[v].csb1; addr1 = vecs[v].addr1;
         tick();
         chk($sformatf("vec%0d_dout0", v), dout0, vecs[v].exp0);
         chk($sformatf("vec%0d_dout1", v), dout1, vecs[v].exp1);
      end

      // flush with a write on the same edge
      idle();
      csb0 = 0; web0 = 0; wmask0 = 4'hF; addr0 = 4'd2; din0 = 32'h12345678; flush0 = 1;
      tick();
      chk("flush_fall", {31'b0, ready0}, 32'd0);
      chk("flush_dout0", dout0, 32'd0);
      idle();
      wait_clear("flush_ready");
      chk("flush_addr2", dout0, IV);
      csb0 = 0; addr0 = 4'd5; csb1 = 0; addr1 = 4'd15;
      tick();
      chk("flush_addr5", dout0, IV);
      chk("flush_addr15", dout1, IV);

      // deselected port 0 holds its index and does not write
      idle();
      csb0 = 0; web0 = 0; wmask0 = 4'hF; addr0 = 4'd1; din0 = 32'hCAFEF00D;
      tick();
      chk("hold_wr", dout0, 32'hCAFEF00D);
      csb0 = 1; din0 = 0;
      for (int j = 0; j < 4; j++) begin
         addr0 = 4'(3 + 2 * j);
         tick();
         chk("hold_dout0", dout0, 32'hCAFEF00D);
      end
      idle();
      csb0 = 0; addr0 = 4'd7; csb1 = 0; addr1 = 4'd3;
      tick();
      chk("hold_nowr7", dout0, IV);
      chk("hold_nowr3", dout1, IV);

      // reset in the middle of a clear restarts it from entry 0
      idle();
      csb0 = 0; web0 = 0; wmask0 = 4'hF; addr0 = 4'd9; din0 = 0;
      tick();
      chk("mid_wr9", dout0, 32'd0);
      idle();
      flush0 = 1;
      tick();
      flush0 = 0;
      repeat (7) tick();
      chk("mid_busy", {31'b0, ready0}, 32'd0);
      rstb0 = 0;
      tick();
      chk("mid_rst", {31'b0, ready0}, 32'd0);
      rstb0 = 1;
      wait_clear("mid_ready");
      csb0 = 0; addr0 = 4'd9; csb1 = 0; addr1 = 4'd1;
      tick();
      chk("mid_addr9", dout0, IV);
      chk("mid_addr1", dout1, IV);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ff_array_2p.md
# ff_array_2p

Parametrised flip-flop array for the cache data and tag stores, replacing single-port arrays where a second read port and sub-word writes are needed. Port 0 is read/write with a per-lane write mask. Port 1 is read-only. A built-in sequential clear engine initialises every entry after reset or on a flush request, so the array holds no per-entry reset logic.

## Interface
- S_INDEX, 4, index width; NUM_SETS = 2**S_INDEX entries
- WIDTH, 32, entry width in bits
- GRAN, 8, write-mask lane width; WIDTH % GRAN == 0 is mandatory (elaboration error otherwise)
- INIT_VALUE, '0, WIDTH-bit value written to every entry by the clear engine
- clk0  in  1  clock; all state updates on the rising edge
- rstb0  in  1  synchronous, active-low reset
- flush0  in  1  request a full clear; honoured only when ready0=1
- ready0  out  1  1 = array usable; 0 = clear in progress
- csb0  in  1  port 0 chip select, active-low
- web0  in  1  port 0 write enable, active-low
- wmask0  in  WIDTH/GRAN  per-lane write enable, active-high
- addr0  in  S_INDEX  port 0 index
- din0  in  WIDTH  port 0 write data
- dout0  out  WIDTH  port 0 read data
- csb1  in  1  port 1 chip select, active-low
- addr1  in  S_INDEX  port 1 index
- dout1  out  WIDTH  port 1 read data

## Operation
- Control FSM states: INIT and READY. ready0 = (state == READY).
- **Reset.** An edge with rstb0=0 sets state=INIT and clr_cnt=0. It also sets addr0_reg and addr1_reg to 0. Entry contents are untouched.
- **INIT.** Each edge writes INIT_VALUE to entry clr_cnt, then increments clr_cnt.
  - At clr_cnt = NUM_SETS-1 the write occurs and state becomes READY.
  - csb0, csb1 and flush0 are ignored. No writes, no address capture.
- **READY, csb0=0.** addr0_reg <= addr0.
  - If web0=0 as well, each lane i with wmask0[i]=1 gets entry[addr0][i*GRAN +: GRAN] <= din0 lane i.
  - Unmasked lanes keep their value. wmask0 = 0 is a legal no-op write.
- **READY, csb1=0.** addr1_reg <= addr1.
- **READY, csb=1.** The port's address register holds its value, so dout re-reads the held index.
- **Outputs.** dout0 = ready0 ? entry[addr0_reg] : '0. dout1 = ready0 ? entry[addr1_reg] : '0. Both are combinational from the registered index.
- **Flush.** flush0=1 sampled in READY: any port 0 write on that edge still commits, then state=INIT and clr_cnt=0.
- **Write-first collision.** A write and a port 1 read to the same index on the same edge: dout1 shows the merged new data after that edge.
- **Reset mid-INIT.** The clear restarts from entry 0.

## Timing
- Read latency is 1 cycle: request sampled at edge N, data valid on doutX after edge N until the next capture.
- Write latency is 1 cycle: entry updated at edge N. dout0 shows the merged data after edge N (write-through).
- Clear duration: for last reset or flush edge R, entries 0..NUM_SETS-1 are cleared on edges R+1..R+NUM_SETS.
  - ready0 rises after edge R+NUM_SETS.
  - ready0 stays 0 from edge R onward.
- Output reset values: ready0=0, dout0='0, dout1='0.
- clr_cnt is S_INDEX bits. Wrap from NUM_SETS-1 to 0 coincides with the INIT→READY transition and must not clear entry 0 twice.

## Structure
- Package ff_array_pkg holds:
  - the FSM state enum ff_array_state_t {INIT, READY};
  - a helper function for lane count WIDTH/GRAN.
- Sub-module ff_array_clr_ctrl holds the FSM plus clr_cnt. It outputs ready, clr_we and clr_addr.
- The top level holds the storage, mask merge and port registers.

## Test plan
- **Reset then clear.** rstb0=0 for 2 cycles, then 1, with S_INDEX=4 and INIT_VALUE=32'hA5A5A5A5. Required: ready0=0 for exactly 16 cycles after the last reset edge, then 1. A read of every index returns A5A5A5A5. Port requests during INIT have no effect.
- **Masked write.** After init to 0, write addr0=3, din0=32'h11223344, wmask0=4'b0101. Required: dout0=32'h00220044 after the write edge. dout1 reads index 3 and returns the same.
- **Write-first collision.** Same edge: port 0 writes addr 5 with 32'hDEADBEEF full mask, port 1 reads addr 5. Required: dout1=DEADBEEF after that edge.
- **Flush with write.** flush0=1 and a write of 32'h12345678 to addr 2 on the same edge. Required:
  - the write commits;
  - ready0 falls after that edge and stays 0 for 16 cycles;
  - afterwards addr 2 reads INIT_VALUE.
- **Mid-clear reset.** rstb0=0 asserted when clr_cnt=7. Required: the clear restarts at entry 0 and takes a full 16 cycles after release.
- **Hold and deselect.** csb0=1 while addr0 toggles. Required: dout0 keeps the previously captured index's data. web0=0 with csb0=1 writes nothing.
